// File: rtl/io_command_arbiter.sv
// Round-robin arbiter sharing one registered IO command port among several requesters.
// Multi-beat commands lock the grant to their owner until the beat marked Last is accepted.
module io_command_arbiter #(
  parameter int DATABITWIDTH     = 16,
  parameter int REGADDRBITWIDTH  = 4,
  parameter int REQUESTERCOUNT   = 4,
  parameter int SOURCEIDBITWIDTH = $clog2(REQUESTERCOUNT)
) (
  input  logic                                       clk,
  input  logic                                       sync_rst,
  input  logic                                       clk_en,
  input  logic [REQUESTERCOUNT-1:0]                  CommandInACK,
  output logic [REQUESTERCOUNT-1:0]                  CommandInREQ,
  input  logic [REQUESTERCOUNT-1:0]                  CommandLastIn,
  input  logic [4*REQUESTERCOUNT-1:0]                MinorOpcodeIn,
  input  logic [REGADDRBITWIDTH*REQUESTERCOUNT-1:0]  RegisterDestIn,
  input  logic [DATABITWIDTH*REQUESTERCOUNT-1:0]     DataAddrIn,
  input  logic [DATABITWIDTH*REQUESTERCOUNT-1:0]     DataIn,
  output logic                                       CommandOutACK,
  input  logic                                       CommandOutREQ,
  output logic [3:0]                                 MinorOpcodeOut,
  output logic [REGADDRBITWIDTH-1:0]                 RegisterDestOut,
  output logic [DATABITWIDTH-1:0]                    DataAddrOut,
  output logic [DATABITWIDTH-1:0]                    DataOut,
  output logic                                       CommandLastOut,
  output logic [SOURCEIDBITWIDTH-1:0]                SourceIDOut
);

  localparam int SW = SOURCEIDBITWIDTH;
  localparam logic [SW-1:0] LAST_ID = SW'(REQUESTERCOUNT - 1);

  // Requester index base+offset, wrapped explicitly so non-power-of-two counts work.
  function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= REQUESTERCOUNT) sum = sum - REQUESTERCOUNT;
    return SW'(sum);
  endfunction

  logic                       out_valid_q, out_valid_d;
  logic [3:0]                 opcode_q, opcode_d;
  logic [REGADDRBITWIDTH-1:0] reg_dest_q, reg_dest_d;
  logic [DATABITWIDTH-1:0]    addr_q, addr_d;
  logic [DATABITWIDTH-1:0]    data_q, data_d;
  logic                       last_q, last_d;
  logic [SW-1:0]              src_q, src_d;
  logic [SW-1:0]              pointer_q, pointer_d;
  logic                       locked_q, locked_d;
  logic [SW-1:0]              lock_id_q, lock_id_d;

  logic                       slot_free;
  logic                       grant_valid;
  logic [SW-1:0]              grant;
  logic [SW-1:0]              search_idx;
  logic [REQUESTERCOUNT-1:0]  req;
  logic                       accept;

  assign slot_free = ~out_valid_q | CommandOutREQ;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    grant       = lock_id_q;
    grant_valid = 1'b0;
    search_idx  = '0;
    if (locked_q) begin
      grant_valid = 1'b1;
    end else begin
      for (int k = 0; k < REQUESTERCOUNT; k++) begin
        search_idx = rr_index(pointer_q, k);
        if (!grant_valid && CommandInACK[search_idx]) begin
          grant       = search_idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req = '0;
    if (grant_valid && slot_free && !sync_rst) req[grant] = 1'b1;
  end

  assign CommandInREQ = req;
  assign accept       = CommandInACK[grant] & req[grant] & clk_en;

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    reg_dest_d  = reg_dest_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    src_d       = src_q;
    pointer_d   = pointer_q;
    locked_d    = locked_q;
    lock_id_d   = lock_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = MinorOpcodeIn[4*grant +: 4];
      reg_dest_d  = RegisterDestIn[REGADDRBITWIDTH*grant +: REGADDRBITWIDTH];
      addr_d      = DataAddrIn[DATABITWIDTH*grant +: DATABITWIDTH];
      data_d      = DataIn[DATABITWIDTH*grant +: DATABITWIDTH];
      last_d      = CommandLastIn[grant];
      src_d       = grant;
      if (CommandLastIn[grant]) begin
        locked_d  = 1'b0;
        pointer_d = (grant == LAST_ID) ? '0 : grant + 1'b1;
      end else begin
        locked_d  = 1'b1;
        lock_id_d = grant;
      end
    end else if (out_valid_q && CommandOutREQ) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      // NOTE: the payload is cleared on reset too, so downstream never sees stale data after reset.
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      reg_dest_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      src_q       <= '0;
      pointer_q   <= '0;
      locked_q    <= 1'b0;
      lock_id_q   <= '0;
    end else if (clk_en) begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      reg_dest_q  <= reg_dest_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      src_q       <= src_d;
      pointer_q   <= pointer_d;
      locked_q    <= locked_d;
      lock_id_q   <= lock_id_d;
    end
  end

  assign CommandOutACK   = out_valid_q;
  assign MinorOpcodeOut  = opcode_q;
  assign RegisterDestOut = reg_dest_q;
  assign DataAddrOut     = addr_q;
  assign DataOut         = data_q;
  assign CommandLastOut  = last_q;
  assign SourceIDOut     = src_q;

endmodule

// File: tb/tb_io_command_arbiter.sv
// Self-checking bench for io_command_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a behavioural arbitration model.
module tb_io_command_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            sync_rst, clk_en, CommandOutREQ;
  logic [N-1:0]    CommandInACK, CommandInREQ, CommandLastIn;
  logic [4*N-1:0]  MinorOpcodeIn;
  logic [RW*N-1:0] RegisterDestIn;
  logic [DW*N-1:0] DataAddrIn, DataIn;
  logic            CommandOutACK, CommandLastOut;
  logic [3:0]      MinorOpcodeOut;
  logic [RW-1:0]   RegisterDestOut;
  logic [DW-1:0]   DataAddrOut, DataOut;
  logic [SW-1:0]   SourceIDOut;

  io_command_arbiter #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(RW), .REQUESTERCOUNT(N)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .CommandInACK(CommandInACK), .CommandInREQ(CommandInREQ), .CommandLastIn(CommandLastIn),
    .MinorOpcodeIn(MinorOpcodeIn), .RegisterDestIn(RegisterDestIn),
    .DataAddrIn(DataAddrIn), .DataIn(DataIn),
    .CommandOutACK(CommandOutACK), .CommandOutREQ(CommandOutREQ),
    .MinorOpcodeOut(MinorOpcodeOut), .RegisterDestOut(RegisterDestOut),
    .DataAddrOut(DataAddrOut), .DataOut(DataOut),
    .CommandLastOut(CommandLastOut), .SourceIDOut(SourceIDOut)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pointer, lock owner (-1 = none) and the output slot contents.
  int         m_ptr = 0;
  int         m_lock = -1;
  bit         m_ov = 1'b0;
  logic [3:0] m_op = '0;
  logic [RW-1:0] m_rd = '0;
  logic [DW-1:0] m_addr = '0, m_data = '0;
  bit         m_last = 1'b0;
  int         m_src = 0;
  logic [N-1:0] req_seen;

  function automatic int model_grant();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < N; k++)
      if (CommandInACK[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_req();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (!sync_rst && g >= 0 && (!m_ov || CommandOutREQ)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    int g;
    bit free;
    g = model_grant();
    free = !m_ov || CommandOutREQ;
    if (sync_rst) begin
      m_ptr = 0; m_lock = -1; m_ov = 0; m_op = '0; m_rd = '0;
      m_addr = '0; m_data = '0; m_last = 0; m_src = 0;
    end else if (clk_en) begin
      if (g >= 0 && CommandInACK[g] && free) begin
        m_ov   = 1'b1;
        m_op   = MinorOpcodeIn[4*g +: 4];
        m_rd   = RegisterDestIn[RW*g +: RW];
        m_addr = DataAddrIn[DW*g +: DW];
        m_data = DataIn[DW*g +: DW];
        m_last = CommandLastIn[g];
        m_src  = g;
        if (CommandLastIn[g]) begin
          m_lock = -1;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock = g;
        end
      end else if (m_ov && CommandOutREQ) begin
        m_ov = 1'b0;
      end
    end
  endtask

  // One clock: check REQ before the edge, advance the model at the edge, check outputs after.
  task automatic cycle();
    #1;
    req_seen = CommandInREQ;
    check("req", 32'(req_seen), 32'(model_req()));
    @(posedge clk);
    model_step();
    #1;
    check("out_ack", 32'(CommandOutACK), 32'(m_ov));
    check("src_id", 32'(SourceIDOut), 32'(m_src));
    check("data", 32'(DataOut), 32'(m_data));
    check("addr", 32'(DataAddrOut), 32'(m_addr));
    check("opcode", 32'(MinorOpcodeOut), 32'(m_op));
    check("reg_dest", 32'(RegisterDestOut), 32'(m_rd));
    check("last", 32'(CommandLastOut), 32'(m_last));
    @(negedge clk);
  endtask

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [3:0]  ack;
    logic [3:0]  last;
    logic        oreq;
    logic [3:0]  exp_req;
    logic        exp_oack;
    logic [1:0]  exp_src;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[19];
  logic [DW-1:0] held_data;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 4'h4, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd2, 16'hBEEF};
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'hD003};
    vecs[4]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'hD000};
    vecs[5]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'hD001};
    vecs[6]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'hBEEF};
    vecs[7]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'hD003};
    vecs[8]  = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 16'hD003};
    vecs[9]  = '{1'b0, 1'b1, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'hD000};
    vecs[10] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'hD000};
    vecs[11] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'hD000};
    vecs[12] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'hD001};
    vecs[13] = '{1'b0, 1'b1, 4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 16'hD001};
    vecs[14] = '{1'b0, 1'b1, 4'h9, 4'h0, 1'b1, 4'h2, 1'b0, 2'd1, 16'hD001};
    vecs[15] = '{1'b0, 1'b1, 4'hB, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 16'hD001};
    vecs[16] = '{1'b0, 1'b1, 4'h9, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 16'hD003};
    vecs[17] = '{1'b0, 1'b1, 4'h9, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 16'hD000};
    vecs[18] = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h0000};

    sync_rst = 1'b1; clk_en = 1'b1; CommandOutREQ = 1'b1;
    CommandInACK = '0; CommandLastIn = '1;
    for (int i = 0; i < N; i++) begin
      MinorOpcodeIn[4*i +: 4]    = (i == 2) ? 4'h3 : 4'(i + 8);
      RegisterDestIn[RW*i +: RW] = RW'(i);
      DataAddrIn[DW*i +: DW]     = (i == 2) ? 16'h0040 : 16'(16'h0100 * i);
      DataIn[DW*i +: DW]         = (i == 2) ? 16'hBEEF : 16'(16'hD000 + i);
    end

    // Directed table: single request, round-robin, clk_en hold, backpressure, short lock.
    for (int v = 0; v < 19; v++) begin
      sync_rst      = vecs[v].rst;
      clk_en        = vecs[v].en;
      CommandInACK  = vecs[v].ack;
      CommandLastIn = vecs[v].last;
      CommandOutREQ = vecs[v].oreq;
      cycle();
      check("tbl_req", 32'(req_seen), 32'(vecs[v].exp_req));
      check("tbl_out_ack", 32'(CommandOutACK), 32'(vecs[v].exp_oack));
      check("tbl_src", 32'(SourceIDOut), 32'(vecs[v].exp_src));
      check("tbl_data", 32'(DataOut), 32'(vecs[v].exp_data));
    end
    check("tbl_single_addr_after_rst", 32'(DataAddrOut), 32'h0);

    // Locked owner stalls for three cycles while requester 0 waits.
    sync_rst = 1'b0; clk_en = 1'b1; CommandOutREQ = 1'b1;
    CommandInACK = 4'b0100; CommandLastIn = 4'b0000;
    cycle();
    check("stall_lock_src", 32'(SourceIDOut), 32'd2);
    for (int i = 0; i < 3; i++) begin
      CommandInACK = 4'b0001;
      cycle();
      check("stall_req0_low", 32'(req_seen[0]), 32'd0);
      check("stall_no_beat", 32'(CommandOutACK), 32'd0);
    end
    CommandInACK = 4'b0101; CommandLastIn = 4'b0100;
    cycle();
    check("stall_resume_src", 32'(SourceIDOut), 32'd2);
    check("stall_resume_last", 32'(CommandLastOut), 32'd1);
    CommandInACK = 4'b0001; CommandLastIn = 4'b1111;
    cycle();
    check("stall_then_0_src", 32'(SourceIDOut), 32'd0);
    check("stall_then_0_ack", 32'(CommandOutACK), 32'd1);

    // Backpressure: five cycles of CommandOutREQ=0 with changing input payload.
    CommandInACK = 4'b1111;
    cycle();
    held_data = DataOut;
    CommandOutREQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      DataIn = {$urandom(), $urandom()};
      cycle();
      check("bp_req_low", 32'(req_seen), 32'd0);
      check("bp_data_held", 32'(DataOut), 32'(held_data));
    end
    CommandOutREQ = 1'b1;
    cycle();
    check("bp_resume_req", 32'(req_seen), 32'b0100);
    check("bp_resume_src", 32'(SourceIDOut), 32'd2);

    // Reset in the middle of a locked multi-beat command.
    CommandInACK = 4'b1111; CommandLastIn = 4'b0000;
    cycle();
    cycle();
    check("rst_lock_src", 32'(SourceIDOut), 32'd3);
    sync_rst = 1'b1;
    cycle();
    check("rst_out_ack", 32'(CommandOutACK), 32'd0);
    sync_rst = 1'b0; CommandLastIn = 4'b1111;
    cycle();
    check("rst_then_req0", 32'(req_seen), 32'b0001);
    check("rst_then_src0", 32'(SourceIDOut), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      sync_rst       = ($urandom_range(0, 63) == 0);
      clk_en         = ($urandom_range(0, 7) != 0);
      CommandInACK   = 4'($urandom());
      CommandLastIn  = 4'($urandom()) | 4'($urandom());
      CommandOutREQ  = ($urandom_range(0, 3) != 0);
      MinorOpcodeIn  = 16'($urandom());
      RegisterDestIn = 16'($urandom());
      DataAddrIn     = {$urandom(), $urandom()};
      DataIn         = {$urandom(), $urandom()};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
